vector_gather_64_col: RTL

VECTOR_GATHER_64_COL -- requirements
Module: vector_gather_64_col

---
 rtl/vector_gather_64_col.sv | 103 ++++++++++
 1 files changed

// File: rtl/vector_gather_64_col.sv
// Gathers four LANE_W-bit lane beats into one packed vector, beat 0 in the top lane.
// A ready/valid handshake on both sides; a full vector holds off input until it is taken.
module vector_gather_64_col #(
   parameter int unsigned LANE_W  = 256,
   parameter int unsigned N_LANES = 4
) (
   input  logic                              clk,
   input  logic                              rst,
   input  logic                              clr,
   input  logic signed [LANE_W-1:0]          in_data,
   input  logic                              in_valid,
   output logic                              in_ready,
   output logic signed [LANE_W*N_LANES-1:0]  out_data,
   output logic                              out_valid,
   input  logic                              out_ready,
   output logic [1:0]                        beat_cnt,
   output logic                              finish
);

   localparam int unsigned VEC_W = LANE_W * N_LANES;

   typedef enum logic [1:0] {
      S_IDLE    = 2'd0,
      S_COLLECT = 2'd1,
      S_FULL    = 2'd2
   } state_t;

   state_t                    r_state;
   state_t                    w_state_nxt;
   logic signed [VEC_W-1:0]   r_out_data;
   logic signed [VEC_W-1:0]   w_out_data_nxt;
   logic                      r_out_valid;
   logic                      w_out_valid_nxt;
   logic [1:0]                r_beat_cnt;
   logic [1:0]                w_beat_cnt_nxt;
   logic                      r_finish;
   logic                      w_finish_nxt;

   // State and registered outputs; reset wins over every other input.
   always_ff @(posedge clk) begin
      if (rst) begin
         r_state     <= S_IDLE;
         r_out_data  <= '0;
         r_out_valid <= 1'b0;
         r_beat_cnt  <= 2'd0;
         r_finish    <= 1'b0;
      end else begin
         r_state     <= w_state_nxt;
         r_out_data  <= w_out_data_nxt;
         r_out_valid <= w_out_valid_nxt;
         r_beat_cnt  <= w_beat_cnt_nxt;
         r_finish    <= w_finish_nxt;
      end
   end

   // Next-state logic: clr only aborts a partial vector, never a full one.
   always_comb begin
      w_state_nxt     = r_state;
      w_out_data_nxt  = r_out_data;
      w_out_valid_nxt = r_out_valid;
      w_beat_cnt_nxt  = r_beat_cnt;
      w_finish_nxt    = 1'b0;

      case (r_state)
         S_IDLE, S_COLLECT: begin
            if (clr) begin
               w_state_nxt    = S_IDLE;
               w_beat_cnt_nxt = 2'd0;
            end else if (in_valid) begin
               for (int unsigned k = 0; k < N_LANES; k++) begin
                  if (r_beat_cnt == 2'(k)) begin
                     w_out_data_nxt[LANE_W*(N_LANES-1-k) +: LANE_W] = in_data;
                  end
               end
               w_beat_cnt_nxt = 2'(r_beat_cnt + 2'd1);
               if (r_beat_cnt == 2'(N_LANES - 1)) begin
                  w_state_nxt     = S_FULL;
                  w_out_valid_nxt = 1'b1;
               end else begin
                  w_state_nxt = S_COLLECT;
               end
            end
         end
         S_FULL: begin
            if (out_ready) begin
               w_state_nxt     = S_IDLE;
               w_out_valid_nxt = 1'b0;
               w_finish_nxt    = 1'b1;
            end
         end
         default: begin
            w_state_nxt = S_IDLE;
         end
      endcase
   end

   assign in_ready  = (r_state != S_FULL);
   assign out_data  = r_out_data;
   assign out_valid = r_out_valid;
   assign beat_cnt  = r_beat_cnt;
   assign finish    = r_finish;

endmodule
